// File: rtl/xor_cipher_pkg.sv
// Shared constants for the serial XOR cipher blocks (encrypt and decrypt sides).
// State encoding is kept as plain constants so legacy code can compare against it.
package xor_cipher_pkg;

   localparam int unsigned MSG_SIZE_DEFAULT = 512;

   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n) + 1;
   endfunction

   localparam int unsigned CNT_W_DEFAULT = cnt_width(MSG_SIZE_DEFAULT);

   localparam logic [1:0] ST_LOAD = 2'd0;
   localparam logic [1:0] ST_XOR  = 2'd1;
   localparam logic [1:0] ST_SEND = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/xor_serial_loader.sv
// MSB-first serial-to-parallel loader: shift-left register with a counter
// that saturates at WIDTH, after which further bits are dropped.
module xor_serial_loader
   import xor_cipher_pkg::*;
#(
   parameter int unsigned WIDTH = MSG_SIZE_DEFAULT,
   parameter int unsigned CW    = cnt_width(WIDTH)
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic             en,
   input  logic             clear,
   input  logic             bit_in,
   input  logic             valid,
   output logic [WIDTH-1:0] data,
   output logic [CW-1:0]    count,
   output logic             full
);

   assign full = (count == CW'(WIDTH));

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         data  <= '0;
         count <= '0;
      end else if (clear) begin
         data  <= '0;
         count <= '0;
      end else if (en && valid && !full) begin
         data  <= {data[WIDTH-2:0], bit_in};
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/xor_decrypt_serial.sv
// Serial XOR decryptor: loads cipher and key streams, XORs them in one cycle,
// then streams the plaintext out MSB first under a valid/ready handshake.
module xor_decrypt_serial
   import xor_cipher_pkg::*;
#(
   parameter int unsigned MSG_SIZE = MSG_SIZE_DEFAULT
) (
   input  logic                     iClk,
   input  logic                     iRst,
   input  logic                     iCipher_bit,
   input  logic                     iCipher_valid,
   input  logic                     iKey_bit,
   input  logic                     iKey_valid,
   input  logic                     iReady,
   input  logic                     iClear,
   output logic                     oPlain_bit,
   output logic                     oPlain_valid,
   output logic [$clog2(MSG_SIZE):0] oCipher_count,
   output logic [$clog2(MSG_SIZE):0] oKey_count,
   output logic                     oBusy,
   output logic                     oDecrypt_done
);

   localparam int unsigned CW = cnt_width(MSG_SIZE);
   localparam int unsigned IW = $clog2(MSG_SIZE);
   localparam logic [IW-1:0] LAST_IDX = IW'(MSG_SIZE - 1);

   logic [1:0]          state;
   logic [MSG_SIZE-1:0] cipher;
   logic [MSG_SIZE-1:0] key;
   logic [MSG_SIZE-1:0] plain;
   logic [IW-1:0]       idx;
   logic                cipher_full;
   logic                key_full;
   logic                in_load;
   logic                restart;

   assign in_load = (state == ST_LOAD);
   assign restart = (state == ST_DONE) && iClear;

   xor_serial_loader #(.WIDTH(MSG_SIZE), .CW(CW)) u_cipher (
      .iClk   (iClk),
      .iRst   (iRst),
      .en     (in_load),
      .clear  (restart),
      .bit_in (iCipher_bit),
      .valid  (iCipher_valid),
      .data   (cipher),
      .count  (oCipher_count),
      .full   (cipher_full)
   );

   xor_serial_loader #(.WIDTH(MSG_SIZE), .CW(CW)) u_key (
      .iClk   (iClk),
      .iRst   (iRst),
      .en     (in_load),
      .clear  (restart),
      .bit_in (iKey_bit),
      .valid  (iKey_valid),
      .data   (key),
      .count  (oKey_count),
      .full   (key_full)
   );

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         state <= ST_LOAD;
         plain <= '0;
         idx   <= '0;
      end else begin
         case (state)
            ST_LOAD: if (cipher_full && key_full) state <= ST_XOR;
            ST_XOR: begin
               plain <= cipher ^ key;
               idx   <= '0;
               state <= ST_SEND;
            end
            ST_SEND: if (iReady) begin
               if (idx == LAST_IDX) state <= ST_DONE;
               else                 idx   <= idx + 1'b1;
            end
            ST_DONE: if (iClear) begin
               plain <= '0;
               idx   <= '0;
               state <= ST_LOAD;
            end
            default: state <= ST_LOAD;
         endcase
      end
   end

   // Output bit is a pure function of state so it stays stable while stalled.
   always_comb begin
      oPlain_valid  = (state == ST_SEND);
      oPlain_bit    = oPlain_valid ? plain[LAST_IDX - idx] : 1'b0;
      oBusy         = (state == ST_XOR) || (state == ST_SEND);
      oDecrypt_done = (state == ST_DONE);
   end

endmodule

// File: tb/tb_xor_decrypt_serial.sv
// Self-checking bench for xor_decrypt_serial at MSG_SIZE=8: vector table,
// reset/clear corner sequences and randomized messages against cipher^key.
module tb_xor_decrypt_serial;

   localparam int unsigned N = 8;

   logic       iClk = 1'b0;
   logic       iRst = 1'b0;
   logic       iCipher_bit = 1'b0, iCipher_valid = 1'b0;
   logic       iKey_bit = 1'b0, iKey_valid = 1'b0;
   logic       iReady = 1'b0, iClear = 1'b0;
   logic       oPlain_bit, oPlain_valid, oBusy, oDecrypt_done;
   logic [3:0] oCipher_count, oKey_count;

   int checks = 0;
   int errors = 0;

   always #5 iClk = ~iClk;

   xor_decrypt_serial #(.MSG_SIZE(N)) dut (
      .iClk          (iClk),
      .iRst          (iRst),
      .iCipher_bit   (iCipher_bit),
      .iCipher_valid (iCipher_valid),
      .iKey_bit      (iKey_bit),
      .iKey_valid    (iKey_valid),
      .iReady        (iReady),
      .iClear        (iClear),
      .oPlain_bit    (oPlain_bit),
      .oPlain_valid  (oPlain_valid),
      .oCipher_count (oCipher_count),
      .oKey_count    (oKey_count),
      .oBusy         (oBusy),
      .oDecrypt_done (oDecrypt_done)
   );

   typedef struct {
      logic [7:0] cipher;
      logic [7:0] key;
      logic [7:0] plain;
      bit         key_first;
      bit         rand_ready;
      bit         clear_in_send;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   task automatic check_idle_zero(input string name);
      check({name, "_valid"}, oPlain_valid, 0);
      check({name, "_bit"}, oPlain_bit, 0);
      check({name, "_busy"}, oBusy, 0);
      check({name, "_done"}, oDecrypt_done, 0);
      check({name, "_ccnt"}, oCipher_count, 0);
      check({name, "_kcnt"}, oKey_count, 0);
   endtask

   // Both streams together, one bit per cycle, then an extra cipher bit.
   task automatic load_simul(input logic [7:0] c, input logic [7:0] k);
      for (int i = 7; i >= 0; i--) begin
         iCipher_bit = c[i]; iKey_bit = k[i];
         iCipher_valid = 1'b1; iKey_valid = 1'b1;
         tick();
         check("simul_ccnt", oCipher_count, 8 - i);
         check("simul_kcnt", oKey_count, 8 - i);
      end
      iKey_valid  = 1'b0;
      iCipher_bit = 1'b1;
      check("load_edge_busy", oBusy, 0);
      tick();
      check("ninth_bit_cnt", oCipher_count, 8);
      check("xor_busy", oBusy, 1);
      check("xor_valid", oPlain_valid, 0);
      iCipher_valid = 1'b0;
      tick();
      check("first_bit_latency", oPlain_valid, 1);
   endtask

   // Random gaps on both streams; extra bits are offered once a stream is full.
   task automatic load_random(input logic [7:0] c, input logic [7:0] k, input bit key_first);
      int ci = 0;
      int ki = 0;
      for (int cyc = 0; cyc < 400 && !(ci == 8 && ki == 8); cyc++) begin
         logic cv, kv;
         kv = ($urandom_range(0, 2) != 0);
         cv = (key_first && ki < 8) ? 1'b0 : ($urandom_range(0, 2) == 0);
         iKey_valid    = kv;
         iKey_bit      = (ki < 8) ? k[7 - ki] : 1'($urandom_range(0, 1));
         iCipher_valid = cv;
         iCipher_bit   = (ci < 8) ? c[7 - ci] : 1'($urandom_range(0, 1));
         if (kv && ki < 8) ki++;
         if (cv && ci < 8) ci++;
         tick();
         check("rand_ccnt", oCipher_count, ci);
         check("rand_kcnt", oKey_count, ki);
         check("busy_during_load", oBusy, 0);
      end
      iCipher_valid = 1'b0;
      iKey_valid    = 1'b0;
      check("load_complete", {oCipher_count, oKey_count}, {4'd8, 4'd8});
   endtask

   task automatic collect(input bit rand_ready, input bit clr, output logic [7:0] got);
      int  n = 0;
      bit  held = 1'b0;
      logic hb = 1'b0;
      got    = '0;
      iClear = clr;
      for (int cyc = 0; cyc < 200 && n < 8; cyc++) begin
         iReady = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (held && oPlain_valid) check("hold_stable", oPlain_bit, hb);
         held = 1'b0;
         if (oPlain_valid) begin
            if (iReady) begin
               got = {got[6:0], oPlain_bit};
               n++;
            end else begin
               held = 1'b1;
               hb   = oPlain_bit;
            end
         end
         tick();
      end
      iReady = 1'b0;
      iClear = 1'b0;
      check("handshake_count", n, 8);
   endtask

   task automatic finish_msg();
      check("done_flag", oDecrypt_done, 1);
      check("done_valid", oPlain_valid, 0);
      check("done_busy", oBusy, 0);
      for (int i = 0; i < 2; i++) begin
         tick();
         check("done_hold", oDecrypt_done, 1);
      end
      iClear = 1'b1;
      tick();
      iClear = 1'b0;
      check_idle_zero("after_clear");
   endtask

   initial begin
      logic [7:0] got, c, k;

      vecs[0] = '{8'hA5, 8'h3C, 8'h99, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{8'hA5, 8'h3C, 8'h99, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{8'h5A, 8'hC3, 8'h99, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{8'h12, 8'h34, 8'h26, 1'b0, 1'b0, 1'b1};
      vecs[4] = '{8'hFF, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{8'h80, 8'h01, 8'h81, 1'b0, 1'b1, 1'b1};

      iCipher_valid = 1'b1; iKey_valid = 1'b1; iCipher_bit = 1'b1; iKey_bit = 1'b1;
      tick();
      tick();
      check_idle_zero("reset");
      iCipher_valid = 1'b0; iKey_valid = 1'b0;
      iRst = 1'b1;
      tick();
      check_idle_zero("post_reset");

      for (int i = 0; i < 6; i++) begin
         if (vecs[i].key_first) load_random(vecs[i].cipher, vecs[i].key, 1'b1);
         else                   load_simul(vecs[i].cipher, vecs[i].key);
         collect(vecs[i].rand_ready, vecs[i].clear_in_send, got);
         check($sformatf("vec%0d_plain", i), got, vecs[i].plain);
         finish_msg();
      end

      // Reset in the middle of SEND, then a fresh message.
      load_simul(8'hA5, 8'h3C);
      iReady = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      check("mid_send_valid", oPlain_valid, 1);
      iRst = 1'b0;
      #1;
      check_idle_zero("async_reset");
      iReady = 1'b0;
      tick();
      check_idle_zero("held_reset");
      iRst = 1'b1;
      load_simul(8'hFF, 8'h0F);
      collect(1'b0, 1'b0, got);
      check("reload_plain", got, 8'hF0);
      finish_msg();

      for (int i = 0; i < 10; i++) begin
         c = 8'($urandom);
         k = 8'($urandom);
         load_random(c, k, 1'($urandom_range(0, 1)));
         collect(1'b1, 1'($urandom_range(0, 1)), got);
         check($sformatf("rand%0d_plain", i), got, c ^ k);
         finish_msg();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
